// File: rtl/rate_counter_pkg.sv
// Shared constants and elaboration helpers for rate_counter and its tick generator.
package rate_counter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NSEL_DEF  = 4;
  localparam int BASE_DEF  = 1;
  localparam int STEP_DEF  = 1;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int sel_w(input int nsel);
    return (clog2(nsel) < 1) ? 1 : clog2(nsel);
  endfunction

  // Prescaler must hold the widest divide exponent the select range can reach.
  function automatic int pre_w(input int base, input int step, input int nsel);
    int w;
    w = base + step * (nsel - 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rate_counter_tick_gen.sv
// Free-running prescaler with clamped rate select; tick_o is high when the low N
// prescaler bits are all ones, N = BASE + STEP*sel_eff.
module rate_counter_tick_gen
  import rate_counter_pkg::*;
#(
  parameter int NSEL = NSEL_DEF,
  parameter int BASE = BASE_DEF,
  parameter int STEP = STEP_DEF,
  localparam int SEL_W = sel_w(NSEL),
  localparam int PRE_W = pre_w(BASE, STEP, NSEL)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [PRE_W-1:0] mask;
  logic [SEL_W-1:0] sel_eff;
  int               n;

  assign pre_d = pre_q + PRE_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  always_comb begin
    sel_eff = sel_i;
    if (int'(sel_i) > NSEL - 1) begin
      sel_eff = SEL_W'(NSEL - 1);
    end
    n = BASE + STEP * int'(sel_eff);
    mask = '0;
    for (int i = 0; i < PRE_W; i++) begin
      mask[i] = (i < n);
    end
  end

  // Bits outside the mask are forced to one, so N=0 gives a constant tick.
  assign tick_o = &(pre_q | ~mask);

endmodule

// File: rtl/rate_counter.sv
// Enable-gated up/down counter stepping on prescaler ticks, wrap or saturate at terminal.
// Optional synchronous load port enabled by defining RATE_COUNTER_LOAD_EN.
module rate_counter
  import rate_counter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NSEL     = NSEL_DEF,
  parameter int BASE     = BASE_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int SATURATE = 0,
  localparam int SEL_W   = sel_w(NSEL)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [SEL_W-1:0] sel_i,
`ifdef RATE_COUNTER_LOAD_EN
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;
  logic             tick;
  logic             at_term;

  rate_counter_tick_gen #(
    .NSEL (NSEL),
    .BASE (BASE),
    .STEP (STEP)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sel_i   (sel_i),
    .tick_o  (tick)
  );

  assign at_term = ((up_i == UP)   && (count_q == '1)) ||
                   ((up_i == DOWN) && (count_q == '0));

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (tick && en_i) begin
      carry_d = at_term;
      if (!(at_term && (SATURATE != 0))) begin
        count_d = (up_i == UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
`ifdef RATE_COUNTER_LOAD_EN
    if (load_i) begin
      count_d = load_val_i;
      carry_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count_o = count_q;
  assign carry_o = carry_q;
  assign tick_o  = tick;

endmodule

// File: tb/tb_rate_counter.sv
// Three rate_counter configurations (wrap, saturate, narrow/clamped select) checked every
// cycle against an arithmetic model, plus literal checks of the documented scenarios.
module tb_rate_counter;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic       car_a, car_b, car_c;
  logic       tk_a, tk_b, tk_c;

  int n_tests = 0;
  int n_fail = 0;

  int m_pre [ND];
  int m_cnt [ND];
  int m_car [ND];
  int c_w    [ND] = '{4, 4, 3};
  int c_nsel [ND] = '{4, 4, 3};
  int c_sat  [ND] = '{0, 1, 0};
  int c_prew [ND] = '{4, 4, 3};

  always #5 clk = ~clk;

  rate_counter #(.WIDTH(4), .NSEL(4), .BASE(1), .STEP(1), .SATURATE(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .sel_i(sel),
`ifdef RATE_COUNTER_LOAD_EN
    .load_i(load), .load_val_i(load_val),
`endif
    .count_o(cnt_a), .carry_o(car_a), .tick_o(tk_a));

  rate_counter #(.WIDTH(4), .NSEL(4), .BASE(1), .STEP(1), .SATURATE(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .sel_i(sel),
`ifdef RATE_COUNTER_LOAD_EN
    .load_i(load), .load_val_i(load_val),
`endif
    .count_o(cnt_b), .carry_o(car_b), .tick_o(tk_b));

  rate_counter #(.WIDTH(3), .NSEL(3), .BASE(1), .STEP(1), .SATURATE(0)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .sel_i(sel),
`ifdef RATE_COUNTER_LOAD_EN
    .load_i(load), .load_val_i(load_val[2:0]),
`endif
    .count_o(cnt_c), .carry_o(car_c), .tick_o(tk_c));

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_n(input int d);
    int s;
    s = int'(sel);
    if (s > c_nsel[d] - 1) s = c_nsel[d] - 1;
    return 1 + s;
  endfunction

  function automatic int m_tick(input int d);
    int r;
    r = 1 << m_n(d);
    return ((m_pre[d] % r) == r - 1) ? 1 : 0;
  endfunction

  // Reference: prescaler is the edge count modulo 2^PRE_W; count moves on ticks.
  always @(posedge clk or negedge rst_n) begin
    int mx;
    int tk;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_pre[d] = 0;
        m_cnt[d] = 0;
        m_car[d] = 0;
      end else begin
        mx = (1 << c_w[d]) - 1;
        tk = m_tick(d) & int'(en);
        m_car[d] = 0;
        if (load) begin
          m_cnt[d] = int'(load_val) & mx;
        end else if (tk != 0) begin
          if (up) begin
            if (m_cnt[d] == mx) begin
              m_car[d] = 1;
              if (c_sat[d] == 0) m_cnt[d] = 0;
            end else m_cnt[d] = m_cnt[d] + 1;
          end else begin
            if (m_cnt[d] == 0) begin
              m_car[d] = 1;
              if (c_sat[d] == 0) m_cnt[d] = mx;
            end else m_cnt[d] = m_cnt[d] - 1;
          end
        end
        m_pre[d] = (m_pre[d] + 1) % (1 << c_prew[d]);
      end
    end
  end

  always @(negedge clk) begin
    check("a_count", int'(cnt_a), m_cnt[0]);
    check("a_carry", int'(car_a), m_car[0]);
    check("a_tick",  int'(tk_a),  m_tick(0));
    check("b_count", int'(cnt_b), m_cnt[1]);
    check("b_carry", int'(car_b), m_car[1]);
    check("b_tick",  int'(tk_b),  m_tick(1));
    check("c_count", int'(cnt_c), m_cnt[2]);
    check("c_carry", int'(car_c), m_car[2]);
    check("c_tick",  int'(tk_c),  m_tick(2));
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Leaves reset released 2 time units after an edge; the next posedge is edge 1.
  task automatic reset_dut();
    rst_n = 1'b0;
    edges(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    check("lit_rst_count", int'(cnt_a), 0);
    check("lit_rst_carry", int'(car_a), 0);
    check("lit_rst_tick",  int'(tk_a), 0);
    en = 1'b1; up = 1'b1; sel = 2'd0;
    edges(1);
    rst_n = 1'b1;

    edges(2);  check("lit_up_e2",  int'(cnt_a), 1);
    edges(28); check("lit_up_e30", int'(cnt_a), 15);
    edges(2);  check("lit_wrap_count", int'(cnt_a), 0);
               check("lit_wrap_carry", int'(car_a), 1);
    edges(1);  check("lit_wrap_carry_off", int'(car_a), 0);

    sel = 2'd3; reset_dut();
    edges(15); check("lit_sel3_e15", int'(cnt_a), 0);
    edges(1);  check("lit_sel3_e16", int'(cnt_a), 1);
    edges(16); check("lit_sel3_e32", int'(cnt_a), 2);

    sel = 2'd0; up = 1'b0; reset_dut();
    edges(2);  check("lit_dn_count", int'(cnt_a), 15);
               check("lit_dn_carry", int'(car_a), 1);
    edges(2);  check("lit_dn_e4", int'(cnt_a), 14);

    up = 1'b1; reset_dut();
    edges(30); check("lit_sat_e30", int'(cnt_b), 15);
    edges(2);  check("lit_sat_hold", int'(cnt_b), 15);
               check("lit_sat_carry", int'(car_b), 1);
    edges(1);  check("lit_sat_carry_off", int'(car_b), 0);
    edges(1);  check("lit_sat_carry_again", int'(car_b), 1);

    reset_dut();
    edges(10); check("lit_en_at5", int'(cnt_a), 5);
    en = 1'b0;
    edges(10); check("lit_en_frozen", int'(cnt_a), 5);
    en = 1'b1;
    edges(2);  check("lit_en_resume", int'(cnt_a), 6);

    reset_dut();
    edges(18); check("lit_mid_at9", int'(cnt_a), 9);
    #1 rst_n = 1'b0;
    #1 check("lit_mid_rst_count", int'(cnt_a), 0);
       check("lit_mid_rst_carry", int'(car_a), 0);
    edges(1);
    rst_n = 1'b1;

`ifdef RATE_COUNTER_LOAD_EN
    en = 1'b0;
    edges(3);
    load = 1'b1; load_val = 4'd12;
    edges(1);  check("lit_load_a", int'(cnt_a), 12);
               check("lit_load_c", int'(cnt_c), 4);
               check("lit_load_carry", int'(car_a), 0);
    load = 1'b0; en = 1'b1;
`endif

    for (int i = 0; i < 3000; i++) begin
      edges(1);
      if (!rst_n) rst_n = 1'b1;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 31) == 0) sel = 2'($urandom_range(0, 3));
`ifdef RATE_COUNTER_LOAD_EN
      load = ($urandom_range(0, 49) == 0);
      load_val = 4'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    load = 1'b0;
    edges(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_counter.md
Name: rate_counter

Overview:
- Parametrised successor of the switch-selected slow-clock counter.
- Runs entirely on one clock domain. Rate selection is an internal prescaler tick (a clock-enable), not a muxed divided clock.
- Counter has configurable width and direction, wrap or saturate mode, a carry pulse and a tick output.
- Sits between board inputs (switches/buttons, already synchronised) and LED/display logic.

Parameters:
- WIDTH, 4: counter width in bits (>=1).
- NSEL, 4: number of selectable rates (>=1); SEL_W = max(1, clog2(NSEL)).
- BASE, 1: log2 of the divide ratio at Sel=0.
- STEP, 1: log2 ratio increment per Sel step.
- SATURATE, 0: 0 = wrap at terminal value, 1 = hold at terminal value.

Ports:
- Clk, input, 1: system clock; all state updates on its rising edge.
- Rst_n, input, 1: asynchronous active-low reset; deassertion is synchronous to Clk externally.
- En, input, 1: count enable.
- Up, input, 1: 1 = count up, 0 = count down.
- Sel, input, SEL_W: rate select; values >= NSEL are treated as NSEL-1.
- Count, output, WIDTH: registered count value.
- Carry, output, 1: registered one-cycle terminal-count pulse.
- Tick, output, 1: combinational prescaler tick (debug/chaining).

Behaviour:
- Reset (Rst_n=0, asynchronous): prescaler=0, Count=0, Carry=0. Tick follows prescaler, so Tick=1 only when N=0.
- Prescaler:
  - PRE_W = max(1, BASE+STEP*(NSEL-1)) bits.
  - Increments by 1 every Clk edge regardless of En; wraps naturally.
  - N = BASE + STEP*Sel_eff.
  - Tick = 1 when the low N prescaler bits are all ones. N=0 means Tick is constantly 1.
  - Divide ratio is 2^N.
- Count update on an edge where Tick=1 and En=1 (effective tick):
  - Up=1: Count+1.
  - Up=0: Count-1.
  - All arithmetic is modulo 2^WIDTH.
- Terminal value: 2^WIDTH-1 when Up=1, 0 when Up=0.
- At terminal on an effective tick:
  - SATURATE=0: wrap (max->0 or 0->max).
  - SATURATE=1: Count holds.
  - In both modes, Carry=1 for exactly the next cycle.
- Carry=0 on every other edge, including all edges with En=0.
- Latency:
  - First effective tick after reset release is edge number 2^N (prescaler reaches 2^N-1).
  - Count changes at that edge.
  - Carry is visible in the same cycle as the wrapped or held Count.
- Sel change mid-run: prescaler is not cleared. The new ratio applies from the next edge, so the first interval may be short.
- Up change: takes effect on the next effective tick; no hysteresis.
- En low: Count frozen, prescaler keeps running.
- Reset mid-count: immediate asynchronous clear of all state, independent of Clk.

Optional Feature:
- Macro: RATE_COUNTER_LOAD_EN.
- When defined:
  - Adds ports Load (input, 1) and LoadVal (input, WIDTH).
  - Load=1 sets Count<=LoadVal on the next edge, overriding tick, En and Up.
  - Carry=0 on that edge.
  - Prescaler is unaffected.
- When undefined: ports are absent and behaviour is as above.

Decomposition:
- Shared package/header holds:
  - default WIDTH/NSEL/BASE/STEP constants;
  - a clog2 constant function;
  - the PRE_W derivation;
  - Up/Down encoding constants (UP=1'b1, DOWN=1'b0).
- One sub-module: tick_gen.
  - Contains the prescaler, Sel clamp and Tick decode.
  - Parameters NSEL, BASE, STEP.
  - Ports Clk, Rst_n, Sel, Tick.
- rate_counter holds the count/carry datapath.

Test Plan (WIDTH=4, NSEL=4, BASE=1, STEP=1, so ratios are 2/4/8/16 unless stated):
- Sel=0, En=1, Up=1 after reset:
  - Count=1 at edge 2, 2 at edge 4, ..., 15 at edge 30.
  - Count=0 with Carry=1 after edge 32; Carry=0 after edge 33.
- Sel=3: Count increments only every 16 edges (1 at edge 16, 2 at edge 32). Tick is high 1 cycle in 16.
- Up=0, Sel=0, starting from 0: Count=15 with Carry=1 after edge 2, then 14 at edge 4.
- SATURATE=1, Up=1, Sel=0: after reaching 15, Count stays 15 and Carry pulses once every 2 cycles.
- En toggled low at Count=5 for 10 cycles: Count stays 5 and Carry stays 0. Resumes on the next tick after En=1.
- Rst_n pulsed low mid-cycle at Count=9: Count=0 and Carry=0 without a Clk edge. With RATE_COUNTER_LOAD_EN, Load=1 with LoadVal=12 gives Count=12 at the next edge, even with En=0.
